// File: rtl/counter_updown_mod.sv
// Purpose : parametrised up/down modulo counter with synchronous load, enable prescaler,
//           wrap/saturate boundary mode, terminal-count pulse and sticky overflow flag.
// Latency : one cycle from CLR/LD/step inputs to Q_OUT/TC_OUT/OVF_OUT (all registered).
// Backpr. : none; the counter accepts a control action on every clock edge.
//
// Ports:
//   CLK      in  1      clock, rising edge
//   CLR      in  1      synchronous active-high clear, highest priority
//   EN       in  1      count enable, also advances the prescaler
//   UP       in  1      direction (1 up, 0 down), sampled on step cycles
//   LD       in  1      synchronous load of D_IN (clamped to MODULUS-1)
//   D_IN     in  WIDTH  load value
//   CLR_OVF  in  1      clears the sticky overflow flag (a same-cycle terminal event wins)
//   Q_OUT    out WIDTH  count value
//   TC_OUT   out 1      one-cycle terminal-count pulse
//   OVF_OUT  out 1      sticky overflow flag
module counter_updown_mod #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int              PRESCALE = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q_OUT,
  output logic             TC_OUT,
  output logic             OVF_OUT
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must be in 2..2^WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("counter_updown_mod: PRESCALE must be in 1..65535");
  end

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Prescaler needs ceil(log2(PRESCALE)) bits but never fewer than one.
  localparam int PW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);

  // Modulus is held in WIDTH+1 bits so MODULUS = 2^WIDTH is representable and
  // the load clamp compare cannot alias through a 2^WIDTH wrap.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // State (power-up value is all-zero, same as after CLR)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] q_q   = '0;
  logic [PW-1:0]    ps_q  = '0;
  logic             tc_q  = 1'b0;
  logic             ovf_q = 1'b0;

  logic [WIDTH-1:0] q_d;
  logic [PW-1:0]    ps_d;
  logic             tc_d;
  logic             ovf_d;

  logic             step;
  logic             at_top;
  logic             at_bottom;
  logic             terminal;
  logic             ld_over;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d       = q_q;
    ps_d      = ps_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    terminal  = 1'b0;

    step      = EN && (ps_q == PS_LAST);
    at_top    = (q_q == MAX_Q);
    at_bottom = (q_q == '0);
    ld_over   = ({1'b0, D_IN} >= MOD_W);

    if (CLR) begin
      q_d   = '0;
      ps_d  = '0;
      ovf_d = 1'b0;
    end else if (LD) begin
      // Out-of-range load values clamp to the top of the count range.
      q_d  = ld_over ? MAX_Q : D_IN;
      ps_d = '0;
    end else if (EN) begin
      if (step) begin
        ps_d = '0;
        if (UP) begin
          if (at_top) begin
            terminal = 1'b1;
            q_d      = SATURATE ? MAX_Q : '0;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end else begin
          if (at_bottom) begin
            terminal = 1'b1;
            q_d      = SATURATE ? '0 : MAX_Q;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end

    // Overflow flag: a terminal event outranks a same-cycle clear request.
    if (!CLR) begin
      if (terminal) begin
        ovf_d = 1'b1;
      end else if (CLR_OVF) begin
        ovf_d = 1'b0;
      end
    end

    tc_d = terminal;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    q_q   <= q_d;
    ps_q  <= ps_d;
    tc_q  <= tc_d;
    ovf_q <= ovf_d;
  end

  assign Q_OUT   = q_q;
  assign TC_OUT  = tc_q;
  assign OVF_OUT = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: wrap, MODULUS=10, PRESCALE=1
  logic       a_clr, a_en, a_up, a_ld, a_clr_ovf;
  logic [7:0] a_din, a_q;
  logic       a_tc, a_ovf;
  // Instance B: saturate, MODULUS=10, PRESCALE=1
  logic       b_clr, b_en, b_up, b_ld, b_clr_ovf;
  logic [7:0] b_din, b_q;
  logic       b_tc, b_ovf;
  // Instance C: wrap, MODULUS=10, PRESCALE=4
  logic       c_clr, c_en, c_up, c_ld, c_clr_ovf;
  logic [7:0] c_din, c_q;
  logic       c_tc, c_ovf;

  counter_updown_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .CLK(clk), .CLR(a_clr), .EN(a_en), .UP(a_up), .LD(a_ld), .D_IN(a_din),
    .CLR_OVF(a_clr_ovf), .Q_OUT(a_q), .TC_OUT(a_tc), .OVF_OUT(a_ovf));

  counter_updown_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1'b1)) u_b (
    .CLK(clk), .CLR(b_clr), .EN(b_en), .UP(b_up), .LD(b_ld), .D_IN(b_din),
    .CLR_OVF(b_clr_ovf), .Q_OUT(b_q), .TC_OUT(b_tc), .OVF_OUT(b_ovf));

  counter_updown_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(4), .SATURATE(1'b0)) u_c (
    .CLK(clk), .CLR(c_clr), .EN(c_en), .UP(c_up), .LD(c_ld), .D_IN(c_din),
    .CLR_OVF(c_clr_ovf), .Q_OUT(c_q), .TC_OUT(c_tc), .OVF_OUT(c_ovf));

  // Advance one rising edge, then settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected Q/TC/OVF for twelve up-steps from 0 (MODULUS=10, wrap).
  logic [7:0] up_q   [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
  logic       up_tc  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       up_ovf [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    a_clr = 1'b1; a_en = 1'b0; a_up = 1'b1; a_ld = 1'b0; a_din = 8'd0; a_clr_ovf = 1'b0;
    b_clr = 1'b1; b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_din = 8'd0; b_clr_ovf = 1'b0;
    c_clr = 1'b1; c_en = 1'b0; c_up = 1'b1; c_ld = 1'b0; c_din = 8'd0; c_clr_ovf = 1'b0;
    #2;
    tick();
    chk("a_rst_q", a_q, 0);   chk("a_rst_tc", a_tc, 0);  chk("a_rst_ovf", a_ovf, 0);
    chk("b_rst_q", b_q, 0);   chk("c_rst_q", c_q, 0);
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;

    // ---------------- Instance A: count up through the wrap ----------------
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("a_up_q[%0d]", i), a_q, up_q[i]);
      chk($sformatf("a_up_tc[%0d]", i), a_tc, up_tc[i]);
      chk($sformatf("a_up_ovf[%0d]", i), a_ovf, up_ovf[i]);
    end

    // Load 0, then step down: wraps to 9 with a TC pulse.
    a_en = 1'b0; a_ld = 1'b1; a_din = 8'd0;
    tick();
    chk("a_ld0_q", a_q, 0); chk("a_ld0_tc", a_tc, 0); chk("a_ld0_ovf", a_ovf, 1);
    a_ld = 1'b0; a_en = 1'b1; a_up = 1'b0;
    tick();
    chk("a_dn_wrap_q", a_q, 9); chk("a_dn_wrap_tc", a_tc, 1);
    tick();
    chk("a_dn_q", a_q, 8); chk("a_dn_tc", a_tc, 0);

    // Load clamp and load-over-enable priority.
    a_en = 1'b0; a_ld = 1'b1; a_din = 8'hFF;
    tick();
    chk("a_ld_clamp_q", a_q, 9);
    a_din = 8'd5; a_en = 1'b1; a_up = 1'b1;
    tick();
    chk("a_ld_en_q", a_q, 5); chk("a_ld_en_tc", a_tc, 0);

    // CLR_OVF alone clears; CLR_OVF with a terminal event loses.
    a_ld = 1'b0; a_en = 1'b0; a_clr_ovf = 1'b1;
    tick();
    chk("a_clrovf_alone", a_ovf, 0);
    a_clr_ovf = 1'b0; a_ld = 1'b1; a_din = 8'd9;
    tick();
    chk("a_ld9_q", a_q, 9);
    a_ld = 1'b0; a_en = 1'b1; a_up = 1'b1; a_clr_ovf = 1'b1;
    tick();
    chk("a_term_clrovf_q", a_q, 0); chk("a_term_clrovf_tc", a_tc, 1);
    chk("a_term_clrovf_ovf", a_ovf, 1);
    a_en = 1'b0;
    tick();
    chk("a_clrovf_later", a_ovf, 0); chk("a_tc_drop", a_tc, 0);
    a_clr_ovf = 1'b0;

    // CLR beats LD and EN and clears the sticky flag.
    a_en = 1'b1; a_up = 1'b0;
    tick();
    chk("a_pre_clr_q", a_q, 9); chk("a_pre_clr_ovf", a_ovf, 1);
    a_clr = 1'b1; a_ld = 1'b1; a_din = 8'd7;
    tick();
    chk("a_clr_all_q", a_q, 0); chk("a_clr_all_tc", a_tc, 0); chk("a_clr_all_ovf", a_ovf, 0);
    a_clr = 1'b0; a_ld = 1'b0; a_en = 1'b0;

    // ---------------- Instance B: saturate mode ----------------
    b_en = 1'b1; b_up = 1'b0;
    tick();
    chk("b_dn_sat_q0", b_q, 0); chk("b_dn_sat_tc0", b_tc, 1); chk("b_dn_sat_ovf", b_ovf, 1);
    tick();
    chk("b_dn_sat_q1", b_q, 0); chk("b_dn_sat_tc1", b_tc, 1);
    b_en = 1'b0;
    tick();
    chk("b_idle_q", b_q, 0); chk("b_idle_tc", b_tc, 0);
    b_ld = 1'b1; b_din = 8'd8;
    tick();
    chk("b_ld8_q", b_q, 8);
    b_ld = 1'b0; b_en = 1'b1; b_up = 1'b1;
    tick();
    chk("b_up_q9", b_q, 9); chk("b_up_tc9", b_tc, 0);
    tick();
    chk("b_up_sat_q0", b_q, 9); chk("b_up_sat_tc0", b_tc, 1);
    tick();
    chk("b_up_sat_q1", b_q, 9); chk("b_up_sat_tc1", b_tc, 1);
    b_en = 1'b0;

    // ---------------- Instance C: prescale by 4 ----------------
    c_en = 1'b1; c_up = 1'b1;
    tick(); chk("c_e1", c_q, 0);
    tick(); chk("c_e2", c_q, 0);
    tick(); chk("c_e3", c_q, 0);
    tick(); chk("c_e4", c_q, 1);
    tick(); chk("c_e5", c_q, 1);
    tick(); chk("c_e6", c_q, 1);
    c_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("c_frozen", c_q, 1);
    c_en = 1'b1;
    tick(); chk("c_resume1", c_q, 1);
    tick(); chk("c_resume2", c_q, 2);

    // Mid-prescale CLR with LD/EN restarts the phase.
    tick(); chk("c_mid", c_q, 2);
    c_clr = 1'b1; c_ld = 1'b1; c_din = 8'd6;
    tick(); chk("c_clr_q", c_q, 0); chk("c_clr_tc", c_tc, 0);
    c_clr = 1'b0; c_ld = 1'b0;
    tick(); tick(); tick();
    chk("c_after_clr3", c_q, 0);
    tick();
    chk("c_after_clr4", c_q, 1);
    c_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down counter with a configurable modulus, synchronous load, an enable prescaler, wrap or saturate mode, and terminal-count/overflow flags. It is the general-purpose successor to the fixed 8-bit up counter. It sits wherever the design needs event counting, timebase division or loop indexing of arbitrary width and range. All state is in the single `CLK` domain.

## Interface
- `WIDTH`, 8: counter width in bits; legal range 1..32.
- `MODULUS`, 256: count range is 0..MODULUS-1. Legal range is 2..2^WIDTH, checked at elaboration.
- `PRESCALE`, 1: number of enabled cycles per count step; legal range 1..65535. A value of 1 steps on every enabled cycle.
- `SATURATE`, 0: 0 wraps at the boundary; 1 holds at the boundary.
- `CLK` input, 1: clock; all activity on the rising edge.
- `CLR` input, 1: reset; synchronous, active-high; highest priority.
- `EN` input, 1: count enable; also gates the prescaler.
- `UP` input, 1: direction; 1 counts up, 0 counts down. Sampled on step cycles only.
- `LD` input, 1: synchronous load of `D_IN`.
- `D_IN` input, WIDTH: load value.
- `CLR_OVF` input, 1: clears the sticky overflow flag.
- `Q_OUT` output, WIDTH: registered count value.
- `TC_OUT` output, 1: registered one-cycle terminal-count pulse.
- `OVF_OUT` output, 1: sticky flag, set by any terminal-count event.

## Operation
- Per-edge priority: `CLR` > `LD` > `EN` step. Lower-priority actions in the same cycle are discarded.
- `CLR`=1 sets `Q_OUT`=0, prescaler=0, `TC_OUT`=0 and `OVF_OUT`=0. It works identically mid-count, mid-prescale, and during `LD` or `EN`.
- The same all-zero state is the power-up (initial) value of every output and internal register.
- `LD`=1 with `CLR`=0:
  - `Q_OUT` takes `D_IN`; if `D_IN` ≥ MODULUS, it takes MODULUS-1 instead.
  - The prescaler resets to 0 and `TC_OUT`=0 for that cycle. `OVF_OUT` is unchanged.
- Prescaler: internal counter of ceil(log2(PRESCALE)) bits, minimum 1 bit.
  - On an `EN`=1 cycle it increments. When it equals PRESCALE-1, that cycle is a step cycle and the prescaler returns to 0.
  - With `EN`=0 the prescaler holds.
  - With PRESCALE=1, every `EN`=1 cycle is a step cycle.
- Step up (`UP`=1): if `Q_OUT` < MODULUS-1, `Q_OUT`+1. If `Q_OUT` = MODULUS-1, this is a terminal event: `Q_OUT` becomes 0 (SATURATE=0) or stays MODULUS-1 (SATURATE=1).
- Step down (`UP`=0): if `Q_OUT` > 0, `Q_OUT`-1. If `Q_OUT` = 0, this is a terminal event: `Q_OUT` becomes MODULUS-1 (SATURATE=0) or stays 0 (SATURATE=1).
- Terminal event:
  - `TC_OUT`=1 on the following cycle only. In saturate mode it re-pulses on every step cycle spent at the boundary.
  - `OVF_OUT` is set.
- `CLR_OVF`=1 clears `OVF_OUT`. If a terminal event occurs in the same cycle, the set wins.
- Arithmetic is done in WIDTH+1 bits, so there is no silent 2^WIDTH wrap. When MODULUS=2^WIDTH, the behaviour equals natural wrap.
- A direction change takes effect on the next step cycle. There is no hidden state tied to direction.

## Timing
- `Q_OUT` updates on the rising edge that ends the `CLR`, `LD` or step cycle. Latency from input to output is one cycle.
- `TC_OUT` is asserted in the cycle after the edge where the terminal event is registered. It is coincident with `Q_OUT` showing the wrapped or held value.
- `OVF_OUT` rises on the same edge as `TC_OUT`.
- With PRESCALE=P and `EN` held high, `Q_OUT` changes once every P cycles. The first change comes P edges after `CLR` or `LD` deasserts.
- `EN` dropping mid-prescale freezes the phase; resuming continues from the frozen phase.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, MODULUS=10, PRESCALE=1: `CLR` pulse, then `EN`=1, `UP`=1 for 12 cycles -> `Q_OUT` goes 0..9, 0, 1. `TC_OUT` is high exactly in the cycle `Q_OUT`=0 after the 9, and `OVF_OUT`=1 thereafter.
- Same configuration with `UP`=0 from `Q_OUT`=0 -> next value is 9, with a `TC_OUT` pulse. Repeat with SATURATE=1 -> `Q_OUT` stays 0, and `TC_OUT` pulses on each step cycle.
- PRESCALE=4, `EN`=1 -> `Q_OUT` increments every 4th cycle. Drop `EN` for 5 cycles after 2 enabled cycles -> the next increment comes exactly 2 enabled cycles after `EN` returns.
- `LD`=1 with `D_IN`=0xFF, MODULUS=10 -> `Q_OUT`=9. `LD`=1 with `D_IN`=5 and `EN`=1 in the same cycle -> `Q_OUT`=5, not 6.
- `CLR`=1 together with `LD`=1, `EN`=1 and `OVF_OUT`=1 -> next cycle `Q_OUT`=0, `TC_OUT`=0, `OVF_OUT`=0, and the prescaler restarts.
- `CLR_OVF`=1 in the same cycle as a terminal event -> `OVF_OUT` stays 1. `CLR_OVF` alone on a later cycle -> `OVF_OUT`=0.
